// File: rtl/fns_cac_decoder.sv
// Receive-side FNS decoder: scans fault flags into an enable mask, then serially
// decodes Fibonacci-weighted TSV codewords to binary, one TSV per clock.
module fns_cac_decoder #(
    parameter int N_TSV  = 8,
    parameter int N_DATA = 6,
    parameter int DATA_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_load,
    input  logic [N_TSV-1:0]  f_flag,
    output logic [N_TSV-1:0]  en_flag,
    output logic              cfg_done,
    output logic              cfg_err,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_TSV-1:0]  cw,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data,
    output logic              err
);

    localparam int IDX_W = (N_TSV > 1) ? $clog2(N_TSV) : 1;
    localparam int CNT_W = $clog2(N_TSV + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_TSV - 1);
    localparam logic [CNT_W-1:0] NDATA_C  = CNT_W'(N_DATA);

    typedef enum logic [2:0] {UNCFG, CFG, IDLE, DEC, OUT} state_t;

    state_t              state_q;
    logic [N_TSV-1:0]    f_q;
    logic [N_TSV-1:0]    en_q;
    logic [N_TSV-1:0]    cw_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [IDX_W-1:0]    idx_q;
    logic [DATA_W-1:0]   acc_q;
    logic [DATA_W-1:0]   w_q;
    logic [DATA_W-1:0]   wp_q;
    logic [DATA_W-1:0]   data_q;
    logic                cfg_done_q;
    logic                cfg_err_q;
    logic                out_valid_q;
    logic                err_q;

    logic                cfg_en_d;
    logic [CNT_W-1:0]    cnt_d;
    logic                dec_en;
    logic                dec_bit;
    logic [DATA_W-1:0]   acc_d;
    logic                err_d;

    // Current-TSV results for the configuration scan and the decode walk.
    always_comb begin
        cfg_en_d = ~f_q[idx_q] & (cnt_q < NDATA_C);
        cnt_d    = cnt_q + CNT_W'(cfg_en_d);
        dec_en   = en_q[idx_q];
        dec_bit  = cw_q[idx_q];
        acc_d    = (dec_en & dec_bit) ? (acc_q + w_q) : acc_q;
        err_d    = err_q | (~dec_en & dec_bit);
    end

    assign in_ready  = (state_q == IDLE) & ~cfg_load;
    assign en_flag   = en_q;
    assign cfg_done  = cfg_done_q;
    assign cfg_err   = cfg_err_q;
    assign out_valid = out_valid_q;
    assign data      = data_q;
    assign err       = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= UNCFG;
            en_q        <= '0;
            cfg_done_q  <= 1'b0;
            cfg_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
            data_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                UNCFG, IDLE: begin
                    if (cfg_load) begin
                        f_q        <= f_flag;
                        en_q       <= '0;
                        cfg_done_q <= 1'b0;
                        cfg_err_q  <= 1'b0;
                        cnt_q      <= '0;
                        idx_q      <= '0;
                        state_q    <= CFG;
                    end else if (state_q == IDLE && in_valid) begin
                        cw_q        <= cw;
                        acc_q       <= '0;
                        err_q       <= 1'b0;
                        w_q         <= DATA_W'(1);
                        wp_q        <= DATA_W'(1);
                        idx_q       <= '0;
                        out_valid_q <= 1'b0;
                        state_q     <= DEC;
                    end
                end
                CFG: begin
                    en_q[idx_q] <= cfg_en_d;
                    cnt_q       <= cnt_d;
                    idx_q       <= idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        if (cnt_d == NDATA_C) begin
                            cfg_done_q <= 1'b1;
                            state_q    <= IDLE;
                        end else begin
                            cfg_err_q <= 1'b1;
                            state_q   <= UNCFG;
                        end
                    end
                end
                DEC: begin
                    acc_q <= acc_d;
                    err_q <= err_d;
                    // Weights advance only on enabled TSVs, giving 1,2,3,5,8,... by healthy rank.
                    if (dec_en) begin
                        w_q  <= w_q + wp_q;
                        wp_q <= w_q;
                    end
                    idx_q <= idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        data_q      <= acc_d;
                        out_valid_q <= 1'b1;
                        state_q     <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= UNCFG;
            endcase
        end
    end

endmodule
